// File: rtl/hypot_isqrt_if.sv
// Start/ready handshake and result bus between the square-root unit and its neighbours.
// The unit drives ready/busy/done and the results; the upstream stage drives start/radicand.
interface hypot_isqrt_seq_if #(
    parameter int unsigned RAD_W = 18
) ();
    localparam int unsigned ROOT_W = RAD_W / 2;

    logic              start;
    logic [RAD_W-1:0]  radicand;
    logic              ready;
    logic              busy;
    logic              done;
    logic [ROOT_W-1:0] root;
    logic [ROOT_W:0]   rem;

    modport master (
        output start, radicand,
        input  ready, busy, done, root, rem
    );

    modport slave (
        input  start, radicand,
        output ready, busy, done, root, rem
    );
endinterface

// File: rtl/hypot_isqrt_seq.sv
// Sequential digit-by-digit integer square root: one root bit per clock,
// floor or round-to-nearest root plus the floor remainder.
module hypot_isqrt_seq #(
    parameter int unsigned RAD_W = 18,
    parameter bit          ROUND = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    hypot_isqrt_seq_if.slave  bus
);
    localparam int unsigned ROOT_W = RAD_W / 2;
    localparam int unsigned REM_W  = ROOT_W + 2;
    localparam int unsigned CNT_W  = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RAD_W-1:0]  sh_q, sh_d;
    logic [ROOT_W-1:0] root_w_q, root_w_d;
    logic [REM_W-1:0]  rem_w_q, rem_w_d;
    logic [ROOT_W-1:0] root_q, root_d;
    logic [ROOT_W:0]   rem_q, rem_d;
    logic              ready_q, busy_q, done_q;

    logic [REM_W+1:0]  r2;
    logic [REM_W+1:0]  t;
    logic              ge;
    logic [REM_W-1:0]  rem_step;
    logic [ROOT_W-1:0] root_step;
    logic [ROOT_W-1:0] root_out;

    // One restoring-subtraction step of the digit-by-digit root
    always_comb begin
        r2        = {rem_w_q, sh_q[RAD_W-1 -: 2]};
        t         = {2'b00, root_w_q, 2'b01};
        ge        = (r2 >= t);
        rem_step  = ge ? REM_W'(r2 - t) : REM_W'(r2);
        root_step = {root_w_q[ROOT_W-2:0], ge};
        root_out  = root_step;
        // Round up when N exceeds r^2 + r, unless the root is already all ones
        if (ROUND && (REM_W'(root_step) < rem_step) && !(&root_step)) begin
            root_out = ROOT_W'(root_step + ROOT_W'(1));
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        root_w_d = root_w_q;
        rem_w_d  = rem_w_q;
        root_d   = root_q;
        rem_d    = rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sh_d     = bus.radicand;
                    root_w_d = '0;
                    rem_w_d  = '0;
                    cnt_d    = CNT_W'(ROOT_W - 1);
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                sh_d     = {sh_q[RAD_W-3:0], 2'b00};
                root_w_d = root_step;
                rem_w_d  = rem_step;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    root_d  = root_out;
                    rem_d   = rem_step[ROOT_W:0];
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they track state_q exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            root_w_q <= '0;
            rem_w_q  <= '0;
            root_q   <= '0;
            rem_q    <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            root_w_q <= root_w_d;
            rem_w_q  <= rem_w_d;
            root_q   <= root_d;
            rem_q    <= rem_d;
            ready_q  <= (state_d == S_IDLE);
            busy_q   <= (state_d == S_CALC);
            done_q   <= (state_d == S_DONE);
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.root  = root_q;
    assign bus.rem   = rem_q;
endmodule

// File: tb/tb_hypot_isqrt_seq.sv
// Bench for hypot_isqrt_seq: a floor and a rounding instance share one stimulus
// stream and are checked against an arithmetic reference model.
module tb_hypot_isqrt_seq;
    localparam int unsigned RAD_W  = 18;
    localparam int unsigned ROOT_W = RAD_W / 2;
    localparam int          MAXR   = (1 << ROOT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [RAD_W-1:0] rad;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // per-operation observations filled by do_op
    int busy_cnt, nrdy_cnt, lat, dn0, dn1;

    hypot_isqrt_seq_if #(.RAD_W(RAD_W)) b0 ();
    hypot_isqrt_seq_if #(.RAD_W(RAD_W)) b1 ();

    assign b0.start    = start;
    assign b0.radicand = rad;
    assign b1.start    = start;
    assign b1.radicand = rad;

    hypot_isqrt_seq #(.RAD_W(RAD_W), .ROUND(1'b0)) dut_floor (.clk(clk), .rst_n(rst_n), .bus(b0));
    hypot_isqrt_seq #(.RAD_W(RAD_W), .ROUND(1'b1)) dut_round (.clk(clk), .rst_n(rst_n), .bus(b1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_floor(input int n);
        int f = 0;
        while ((f + 1) * (f + 1) <= n) f++;
        return f;
    endfunction

    // Nearest integer to sqrt(n); ties cannot occur for integer n
    function automatic int ref_round(input int n);
        int f = ref_floor(n);
        int r = (((f + 1) * (f + 1) - n) < (n - f * f)) ? f + 1 : f;
        return (r > MAXR) ? MAXR : r;
    endfunction

    // Issue one start pulse and watch the status lines until one cycle past done
    task automatic do_op(input logic [RAD_W-1:0] n);
        busy_cnt = 0; nrdy_cnt = 0; lat = -1; dn0 = 0; dn1 = 0;
        @(negedge clk);
        start = 1'b1;
        rad   = n;
        @(negedge clk);
        start = 1'b0;
        rad   = RAD_W'($urandom);
        for (int i = 0; i < 20; i++) begin
            if (b0.busy)  busy_cnt++;
            if (!b0.ready) nrdy_cnt++;
            if (b0.done) dn0++;
            if (b1.done) dn1++;
            if (b0.done && lat < 0) lat = i;
            if (lat >= 0 && i == lat + 1) break;
            @(negedge clk);
        end
    endtask

    task automatic check_op(input string tag, input int n);
        check({tag, ".lat"},     32'(lat), 32'd9);
        check({tag, ".busy"},    32'(busy_cnt), 32'(ROOT_W));
        check({tag, ".nready"},  32'(nrdy_cnt), 32'(ROOT_W + 1));
        check({tag, ".done0"},   32'(dn0), 32'd1);
        check({tag, ".done1"},   32'(dn1), 32'd1);
        check({tag, ".root0"},   32'(b0.root), 32'(ref_floor(n)));
        check({tag, ".rem0"},    32'(b0.rem), 32'(n - ref_floor(n) * ref_floor(n)));
        check({tag, ".root1"},   32'(b1.root), 32'(ref_round(n)));
        check({tag, ".rem1"},    32'(b1.rem), 32'(n - ref_floor(n) * ref_floor(n)));
    endtask

    initial begin
        int d_idx[$];
        int n, r;
        rst_n = 1'b0;
        start = 1'b0;
        rad   = '0;
        repeat (2) @(negedge clk);
        check("rst.ready", 32'(b0.ready), 32'd1);
        check("rst.busy",  32'(b0.busy),  32'd0);
        check("rst.done",  32'(b0.done),  32'd0);
        check("rst.root",  32'(b0.root),  32'd0);
        check("rst.rem",   32'(b1.rem),   32'd0);
        rst_n = 1'b1;

        // Directed operands including zero, the (255,255) maximum and all-ones
        do_op(RAD_W'(25));     check_op("t25", 25);
        check("t25.root", 32'(b0.root), 32'd5);
        do_op(RAD_W'(130050)); check_op("t130050", 130050);
        check("t130050.root1", 32'(b1.root), 32'd361);
        check("t130050.rem",   32'(b0.rem),  32'd450);
        do_op(RAD_W'(0));      check_op("t0", 0);
        do_op(RAD_W'(262143)); check_op("tmax", 262143);
        check("tmax.root1", 32'(b1.root), 32'd511);
        check("tmax.rem1",  32'(b1.rem),  32'd1022);

        // start held high: second op accepted at E11, radicand change at E1 ignored
        @(negedge clk);
        start = 1'b1;
        rad   = RAD_W'(169);
        @(negedge clk);
        rad = RAD_W'(2);
        for (int i = 0; i < 30; i++) begin
            if (b0.done) begin
                d_idx.push_back(i);
                if (d_idx.size() == 1) begin
                    check("hs.op1.root", 32'(b0.root), 32'd13);
                    check("hs.op1.rem",  32'(b0.rem),  32'd0);
                end else begin
                    check("hs.op2.root", 32'(b0.root), 32'd1);
                    check("hs.op2.rem",  32'(b0.rem),  32'd1);
                    start = 1'b0;
                end
            end
            if (i == 10) check("hs.ready_e10", 32'(b0.ready), 32'd1);
            @(negedge clk);
        end
        check("hs.ndone", 32'(d_idx.size()), 32'd2);
        if (d_idx.size() == 2) begin
            check("hs.idx1", 32'(d_idx[0]), 32'd9);
            check("hs.idx2", 32'(d_idx[1]), 32'd20);
        end

        // Asynchronous reset in the fourth CALC cycle
        @(negedge clk);
        start = 1'b1;
        rad   = RAD_W'(400);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar.ready", 32'(b0.ready), 32'd1);
        check("ar.busy",  32'(b0.busy),  32'd0);
        check("ar.done",  32'(b0.done),  32'd0);
        check("ar.root0", 32'(b0.root),  32'd0);
        check("ar.rem0",  32'(b0.rem),   32'd0);
        check("ar.root1", 32'(b1.root),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(RAD_W'(400)); check_op("ar400", 400);
        check("ar400.root", 32'(b0.root), 32'd20);

        // Randomized sweep; include extra coverage below the (255,255) maximum
        for (int k = 0; k < 1000; k++) begin
            n = (k % 2 == 0) ? int'($urandom_range(0, 130050)) : int'($urandom_range(0, 262143));
            do_op(RAD_W'(n));
            check_op("rnd", n);
            r = int'(b0.root);
            check("rnd.bracket", 32'((r * r <= n) && (n < (r + 1) * (r + 1))), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
